// File: rtl/jtgng_sdram_rq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_sdram_rq_pkg
//  Purpose  : Shared types and constants for the SDRAM ROM read arbiter.
//             Holds the default bus widths, the legal parameter ranges, the
//             in-flight pipe entry layout, the readiness state encoding and
//             the round-robin pointer helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package jtgng_sdram_rq_pkg;

  // Default SDRAM word-address and data widths
  localparam int c_def_aw    = 22;
  localparam int c_def_dw    = 16;

  // Legal configuration ranges
  localparam int c_lat_min   = 1;
  localparam int c_lat_max   = 3;
  localparam int c_chn_min   = 2;
  localparam int c_chn_max   = 8;

  // Channel index field in the pipe is sized for the largest legal CHN
  localparam int c_chw_max   = 3;

  // Consecutive cen ticks without a download before the arbiter opens
  localparam int c_rdy_ticks = 4;

  // One in-flight read: which channel it belongs to and, for byte
  // channels, which half of the SDRAM word carries the requested byte.
  typedef struct packed {
    logic                 v;
    logic [c_chw_max-1:0] ch;
    logic                 lsb;
  } pipe_t;

  // Readiness tracking: warming up after reset/download, or operational
  typedef enum logic [0:0] {
    RQ_WARMUP = 1'b0,
    RQ_READY  = 1'b1
  } rq_state_t;

  // Round-robin pointer advance: channel after idx, wrapping at chn
  function automatic int rq_next_ptr(input int idx, input int chn);
    return (idx + 1 >= chn) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtgng_sdram_rq_if.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_sdram_rq_if
//  Purpose  : Bus bundle between ROM clients / SDRAM controller and the
//             read arbiter.
//  Signals  : req        per-channel read request (level)
//             addr       per-channel address, CHN*AW packed
//             dout       per-channel read data, CHN*DW packed
//             data_ok    per-channel completion pulse
//             sdram_addr word address to SDRAM controller
//             sdram_re   toggles once per issued read
//             data_read  SDRAM read data
//  Modports : master - clients and SDRAM controller side
//             slave  - arbiter side
//  Revision : 1.0  initial release
// ============================================================================
interface jtgng_sdram_rq_if #(
  parameter int CHN = 4,
  parameter int AW  = jtgng_sdram_rq_pkg::c_def_aw,
  parameter int DW  = jtgng_sdram_rq_pkg::c_def_dw
);

  logic [CHN-1:0]    req;
  logic [CHN*AW-1:0] addr;
  logic [CHN*DW-1:0] dout;
  logic [CHN-1:0]    data_ok;
  logic [AW-1:0]     sdram_addr;
  logic              sdram_re;
  logic [DW-1:0]     data_read;

  modport master (
    output req, addr, data_read,
    input  dout, data_ok, sdram_addr, sdram_re
  );

  modport slave (
    input  req, addr, data_read,
    output dout, data_ok, sdram_addr, sdram_re
  );

endinterface
`default_nettype wire

// File: rtl/jtgng_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_rr_arb
//  Purpose  : Combinational round-robin arbiter. Searches the eligible
//             vector starting at the pointer and returns the first hit.
//  Ports    : i_en        arbitration enabled this cycle
//             i_eligible  per-channel eligibility
//             i_ptr       channel where the search starts
//             o_grant     one-hot grant
//             o_valid     a grant was made
//             o_idx       encoded index of the granted channel
//  Revision : 1.0  initial release
// ============================================================================
module jtgng_rr_arb #(
  parameter int CHN = 4,
  parameter int CW  = (CHN > 1) ? $clog2(CHN) : 1
) (
  input  logic           i_en,
  input  logic [CHN-1:0] i_eligible,
  input  logic [CW-1:0]  i_ptr,
  output logic [CHN-1:0] o_grant,
  output logic           o_valid,
  output logic [CW-1:0]  o_idx
);

  logic [CW:0] w_c;
  logic        w_hit;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_hit   = 1'b0;
    w_c     = '0;
    for (int i = 0; i < CHN; i++) begin
      // Candidate channel (ptr + i) mod CHN; one extra bit holds the carry
      w_c = {1'b0, i_ptr} + (CW+1)'(i);
      if (w_c >= (CW+1)'(CHN)) begin
        w_c = w_c - (CW+1)'(CHN);
      end
      if (i_en && !w_hit && i_eligible[w_c[CW-1:0]]) begin
        w_hit                  = 1'b1;
        o_idx                  = w_c[CW-1:0];
        o_grant[w_c[CW-1:0]]   = 1'b1;
      end
    end
  end

  assign o_valid = w_hit;

endmodule
`default_nettype wire

// File: rtl/jtgng_sdram_rq.sv
`default_nettype none
// ============================================================================
//  Module   : jtgng_sdram_rq
//  Purpose  : SDRAM read arbiter for game ROM clients. CHN request/ack
//             channels share one SDRAM read port with round-robin grants,
//             per-channel region offsets, byte/word modes, a LAT-tick read
//             pipe and refresh slots during vertical blank.
//  Ports    : clk            system clock
//             rst            asynchronous active-high reset
//             i_cen          clock enable, one arbitration tick per cen
//             i_downloading  ROM download in progress, flushes the block
//             i_lvbl         vertical blank, active low
//             o_ready        arbiter operational
//             o_autorefresh  refresh slot request, one tick
//             bus            client / SDRAM bundle (slave side)
//  Revision : 1.0  initial release
// ============================================================================
module jtgng_sdram_rq
  import jtgng_sdram_rq_pkg::*;
#(
  parameter int                CHN       = 4,
  parameter int                AW        = c_def_aw,
  parameter int                DW        = c_def_dw,
  parameter int                LAT       = 1,
  parameter logic [CHN*AW-1:0] OFFSETS   = '0,
  parameter logic [CHN-1:0]    BYTE_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cen,
  input  logic             i_downloading,
  input  logic             i_lvbl,
  output logic             o_ready,
  output logic             o_autorefresh,
  jtgng_sdram_rq_if.slave  bus
);

  localparam int c_cw = (CHN > 1) ? $clog2(CHN) : 1;

  generate
    if (LAT < c_lat_min || LAT > c_lat_max ||
        CHN < c_chn_min || CHN > c_chn_max) begin : g_param_check
      $error("jtgng_sdram_rq: LAT must be 1..3 and CHN 2..8");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  rq_state_t        r_state;
  rq_state_t        w_state_nxt;
  logic [1:0]       r_rdy_cnt;
  logic [1:0]       w_rdy_cnt_nxt;

  logic [c_cw-1:0]  r_ptr;
  pipe_t            r_pipe [LAT];
  logic [CHN-1:0]   r_done;
  logic [CHN-1:0]   r_data_ok;
  logic [AW-1:0]    r_latched [CHN];
  logic [DW-1:0]    r_dout    [CHN];
  logic [AW-1:0]    r_sdram_addr;
  logic             r_sdram_re;
  logic             r_autorefresh;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic [AW-1:0]    w_addr  [CHN];
  logic [AW-1:0]    w_saddr [CHN];
  logic [CHN-1:0]   w_done_eff;
  logic [CHN-1:0]   w_eligible;
  logic [CHN-1:0]   w_inflight;
  logic [CHN-1:0]   w_cap;
  logic [CHN-1:0]   w_gnt;
  logic             w_gnt_valid;
  logic [c_cw-1:0]  w_gnt_idx;
  logic             w_arb_en;
  logic             w_refresh;
  logic             w_tick;
  logic [DW-1:0]    w_byte_data;
  pipe_t            w_new;

  assign w_tick   = i_cen & ~i_downloading;
  assign w_arb_en = w_tick & (r_state == RQ_READY);

  generate
    for (genvar c = 0; c < CHN; c++) begin : g_chan
      assign w_addr[c] = bus.addr[c*AW +: AW];

      // OFFSETS are word addresses; byte channels drop the byte-lane bit.
      // The adder wraps at 2^AW by construction.
      if (BYTE_MASK[c]) begin : g_byte
        assign w_saddr[c] = OFFSETS[c*AW +: AW] + {1'b0, w_addr[c][AW-1:1]};
      end else begin : g_word
        assign w_saddr[c] = OFFSETS[c*AW +: AW] + w_addr[c];
      end

      // A completed channel stays quiet only while it keeps asking for the
      // same address; a dropped request or a new address re-arms it at once.
      assign w_done_eff[c] = r_done[c] & bus.req[c] & (w_addr[c] == r_latched[c]);
      assign w_eligible[c] = bus.req[c] & ~w_inflight[c] & ~w_done_eff[c];
      assign w_cap[c]      = r_pipe[LAT-1].v &
                             (r_pipe[LAT-1].ch == c_chw_max'(c));
    end
  endgenerate

  // Every pipe stage, including the one leaving this tick, blocks its channel
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < LAT; k++) begin
      if (r_pipe[k].v) begin
        w_inflight[r_pipe[k].ch[c_cw-1:0]] = 1'b1;
      end
    end
  end

  jtgng_rr_arb #(
    .CHN (CHN),
    .CW  (c_cw)
  ) u_arb (
    .i_en       (w_arb_en),
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_gnt),
    .o_valid    (w_gnt_valid),
    .o_idx      (w_gnt_idx)
  );

  always_comb begin
    w_new     = '0;
    w_new.v   = w_gnt_valid;
    w_new.ch  = c_chw_max'(w_gnt_idx);
    w_new.lsb = w_addr[w_gnt_idx][0] & BYTE_MASK[w_gnt_idx];
  end

  // Refresh only fills otherwise idle ticks of an operational arbiter
  assign w_refresh = (r_state == RQ_READY) & ~(|w_eligible) & ~i_lvbl;

  // Even byte address lives in the high half of the SDRAM word
  assign w_byte_data = {{(DW-8){1'b0}},
                        r_pipe[LAT-1].lsb ? bus.data_read[7:0] : bus.data_read[15:8]};

  // --------------------------------------------------------------------------
  // Readiness FSM
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_rdy_cnt_nxt = r_rdy_cnt;
    if (i_downloading) begin
      w_state_nxt   = RQ_WARMUP;
      w_rdy_cnt_nxt = '0;
    end else if (i_cen) begin
      case (r_state)
        RQ_WARMUP: begin
          if (r_rdy_cnt == 2'(c_rdy_ticks - 1)) begin
            w_state_nxt = RQ_READY;
          end else begin
            w_rdy_cnt_nxt = r_rdy_cnt + 2'd1;
          end
        end
        RQ_READY: w_state_nxt = RQ_READY;
        default:  w_state_nxt = RQ_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RQ_WARMUP;
      r_rdy_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rdy_cnt <= w_rdy_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Grant side: pointer, SDRAM address, read toggle, refresh
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_sdram_addr  <= '0;
      r_sdram_re    <= 1'b0;
      r_autorefresh <= 1'b0;
    end else if (i_downloading) begin
      r_ptr         <= '0;
      r_autorefresh <= 1'b0;
    end else if (i_cen) begin
      r_autorefresh <= w_refresh;
      if (w_gnt_valid) begin
        r_ptr        <= c_cw'(rq_next_ptr(int'(w_gnt_idx), CHN));
        r_sdram_addr <= w_saddr[w_gnt_idx];
        r_sdram_re   <= ~r_sdram_re;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHN; c++) begin
        r_latched[c] <= '0;
      end
    end else if (w_arb_en) begin
      for (int c = 0; c < CHN; c++) begin
        if (w_gnt[c]) begin
          r_latched[c] <= w_addr[c];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // In-flight pipe
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (i_downloading) begin
      for (int k = 0; k < LAT; k++) begin
        r_pipe[k] <= '0;
      end
    end else if (i_cen) begin
      r_pipe[0] <= w_new;
      for (int k = 1; k < LAT; k++) begin
        r_pipe[k] <= r_pipe[k-1];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture side: data, completion pulse, done flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHN; c++) begin
        r_dout[c] <= '0;
      end
    end else if (w_tick) begin
      for (int c = 0; c < CHN; c++) begin
        if (w_cap[c]) begin
          r_dout[c] <= BYTE_MASK[c] ? w_byte_data : bus.data_read;
        end
      end
    end
  end

  // data_ok is one clk wide no matter how sparse cen is
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_ok <= '0;
      r_done    <= '0;
    end else begin
      r_data_ok <= w_tick ? w_cap : '0;
      if (i_downloading) begin
        r_done <= '0;
      end else begin
        r_done <= w_done_eff | (i_cen ? w_cap : '0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus.dout = '0;
    for (int c = 0; c < CHN; c++) begin
      bus.dout[c*DW +: DW] = r_dout[c];
    end
  end

  assign bus.data_ok    = r_data_ok;
  assign bus.sdram_addr = r_sdram_addr;
  assign bus.sdram_re   = r_sdram_re;
  assign o_ready        = (r_state == RQ_READY);
  assign o_autorefresh  = r_autorefresh;

endmodule
`default_nettype wire

// File: tb/tb_jtgng_sdram_rq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtgng_sdram_rq
//  Purpose  : Directed self-checking bench for jtgng_sdram_rq. Two
//             instances: u_a with LAT=1 for the main function, u_b with
//             LAT=3 for the download flush.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtgng_sdram_rq;

  localparam int CHN = 4;
  localparam int AW  = 22;
  localparam int DW  = 16;
  // ch3..ch0 region bases
  localparam logic [CHN*AW-1:0] OFFS = {22'h000000, 22'h3FFFF0, 22'h00A000, 22'h020000};
  localparam logic [CHN-1:0]    BMASK = 4'b0010;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic cen  = 1'b0;
  logic lvbl = 1'b1;
  logic dl_a = 1'b0;
  logic dl_b = 1'b0;
  logic ready_a, ready_b, aref_a, aref_b;

  int n_pass  = 0;
  int n_total = 0;

  jtgng_sdram_rq_if #(.CHN(CHN), .AW(AW), .DW(DW)) bus_a ();
  jtgng_sdram_rq_if #(.CHN(CHN), .AW(AW), .DW(DW)) bus_b ();

  jtgng_sdram_rq #(
    .CHN(CHN), .AW(AW), .DW(DW), .LAT(1), .OFFSETS(OFFS), .BYTE_MASK(BMASK)
  ) u_a (
    .clk(clk), .rst(rst), .i_cen(cen), .i_downloading(dl_a), .i_lvbl(lvbl),
    .o_ready(ready_a), .o_autorefresh(aref_a), .bus(bus_a)
  );

  jtgng_sdram_rq #(
    .CHN(CHN), .AW(AW), .DW(DW), .LAT(3), .OFFSETS(OFFS), .BYTE_MASK(BMASK)
  ) u_b (
    .clk(clk), .rst(rst), .i_cen(cen), .i_downloading(dl_b), .i_lvbl(lvbl),
    .o_ready(ready_b), .o_autorefresh(aref_b), .bus(bus_b)
  );

  always #5 clk = ~clk;
  // cen high on every other rising edge
  always @(negedge clk) cen = ~cen;

  task automatic tick();
    @(posedge clk);
    while (!cen) @(posedge clk);
    #1;
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.req = '0; bus_a.addr = '0; bus_a.data_read = '0;
    bus_b.req = '0; bus_b.addr = '0; bus_b.data_read = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (ready_a !== 1'b0) $display("FAIL reset_ready got=%0b exp=0", ready_a); else n_pass++;
    n_total++; if (aref_a !== 1'b0) $display("FAIL reset_aref got=%0b exp=0", aref_a); else n_pass++;
    n_total++; if (bus_a.sdram_re !== 1'b0) $display("FAIL reset_re got=%0b exp=0", bus_a.sdram_re); else n_pass++;
    n_total++; if (bus_a.sdram_addr !== 22'h0) $display("FAIL reset_saddr got=%h exp=0", bus_a.sdram_addr); else n_pass++;
    n_total++; if (bus_a.data_ok !== 4'h0) $display("FAIL reset_dok got=%b exp=0000", bus_a.data_ok); else n_pass++;
    n_total++; if (bus_a.dout !== 64'h0) $display("FAIL reset_dout got=%h exp=0", bus_a.dout); else n_pass++;
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_total++;
      if (ready_a !== (i == 4)) $display("FAIL ready_rise tick=%0d got=%0b exp=%0b", i, ready_a, (i == 4));
      else n_pass++;
    end
    n_total++; if (ready_b !== 1'b1) $display("FAIL ready_b got=%0b exp=1", ready_b); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [21:0] ea  [4] = '{22'h020010, 22'h00A004, 22'h3FFFF1, 22'h000007};
    logic [15:0] dr  [6] = '{16'h0000, 16'h0000, 16'h1111, 16'h2233, 16'h3333, 16'h4444};
    logic [3:0]  eok [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic prev;
    bus_a.addr = {22'h000007, 22'h000001, 22'h000008, 22'h000010};
    bus_a.req  = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      bus_a.data_read = dr[i];
      prev = bus_a.sdram_re;
      tick();
      if (i <= 4) begin
        n_total++;
        if (bus_a.sdram_addr !== ea[i-1]) $display("FAIL b2b_saddr tick=%0d got=%h exp=%h", i, bus_a.sdram_addr, ea[i-1]);
        else n_pass++;
        n_total++;
        if (bus_a.sdram_re !== ~prev) $display("FAIL b2b_re tick=%0d got=%0b exp=%0b", i, bus_a.sdram_re, ~prev);
        else n_pass++;
      end
      n_total++;
      if (bus_a.data_ok !== eok[i]) $display("FAIL b2b_dok tick=%0d got=%b exp=%b", i, bus_a.data_ok, eok[i]);
      else n_pass++;
    end
    clk_step();
    n_total++; if (bus_a.data_ok !== 4'h0) $display("FAIL b2b_dok_width got=%b exp=0000", bus_a.data_ok); else n_pass++;
    n_total++; if (bus_a.dout[15:0]  !== 16'h1111) $display("FAIL b2b_dout0 got=%h exp=1111", bus_a.dout[15:0]);  else n_pass++;
    n_total++; if (bus_a.dout[31:16] !== 16'h0022) $display("FAIL b2b_dout1 got=%h exp=0022", bus_a.dout[31:16]); else n_pass++;
    n_total++; if (bus_a.dout[47:32] !== 16'h3333) $display("FAIL b2b_dout2 got=%h exp=3333", bus_a.dout[47:32]); else n_pass++;
    n_total++; if (bus_a.dout[63:48] !== 16'h4444) $display("FAIL b2b_dout3 got=%h exp=4444", bus_a.dout[63:48]); else n_pass++;
    prev = bus_a.sdram_re;
    tick();
    tick();
    n_total++; if (bus_a.sdram_re !== prev) $display("FAIL b2b_no_regrant got=%0b exp=%0b", bus_a.sdram_re, prev); else n_pass++;
    bus_a.req = '0;
    tick();
  endtask

  task automatic test_word();
    logic prev;
    bus_a.addr[21:0] = 22'h000123;
    bus_a.req[0]     = 1'b1;
    prev = bus_a.sdram_re;
    tick();
    n_total++; if (bus_a.sdram_addr !== 22'h020123) $display("FAIL word_saddr got=%h exp=020123", bus_a.sdram_addr); else n_pass++;
    n_total++; if (bus_a.sdram_re !== ~prev) $display("FAIL word_re got=%0b exp=%0b", bus_a.sdram_re, ~prev); else n_pass++;
    bus_a.data_read = 16'hBEEF;
    tick();
    n_total++; if (bus_a.data_ok !== 4'b0001) $display("FAIL word_dok got=%b exp=0001", bus_a.data_ok); else n_pass++;
    n_total++; if (bus_a.dout[15:0] !== 16'hBEEF) $display("FAIL word_dout got=%h exp=BEEF", bus_a.dout[15:0]); else n_pass++;
    clk_step();
    n_total++; if (bus_a.data_ok !== 4'b0000) $display("FAIL word_dok_width got=%b exp=0000", bus_a.data_ok); else n_pass++;
    prev = bus_a.sdram_re;
    tick();
    n_total++; if (bus_a.sdram_re !== prev) $display("FAIL word_no_regrant got=%0b exp=%0b", bus_a.sdram_re, prev); else n_pass++;
    bus_a.req[0] = 1'b0;
    tick();
  endtask

  task automatic test_byte();
    logic prev;
    bus_a.addr[43:22] = 22'h000005;
    bus_a.req[1]      = 1'b1;
    tick();
    n_total++; if (bus_a.sdram_addr !== 22'h00A002) $display("FAIL byte_saddr_odd got=%h exp=00A002", bus_a.sdram_addr); else n_pass++;
    bus_a.data_read = 16'h1234;
    tick();
    n_total++; if (bus_a.data_ok !== 4'b0010) $display("FAIL byte_dok_odd got=%b exp=0010", bus_a.data_ok); else n_pass++;
    n_total++; if (bus_a.dout[31:16] !== 16'h0034) $display("FAIL byte_dout_odd got=%h exp=0034", bus_a.dout[31:16]); else n_pass++;
    // New address with req held re-triggers a read
    bus_a.addr[43:22] = 22'h000004;
    bus_a.data_read   = 16'h0000;
    prev = bus_a.sdram_re;
    tick();
    n_total++; if (bus_a.sdram_re !== ~prev) $display("FAIL byte_retrigger got=%0b exp=%0b", bus_a.sdram_re, ~prev); else n_pass++;
    n_total++; if (bus_a.sdram_addr !== 22'h00A002) $display("FAIL byte_saddr_even got=%h exp=00A002", bus_a.sdram_addr); else n_pass++;
    bus_a.data_read = 16'h1234;
    tick();
    n_total++; if (bus_a.dout[31:16] !== 16'h0012) $display("FAIL byte_dout_even got=%h exp=0012", bus_a.dout[31:16]); else n_pass++;
    bus_a.req[1] = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    bus_a.addr[65:44] = 22'h000020;
    bus_a.req[2]      = 1'b1;
    tick();
    n_total++; if (bus_a.sdram_addr !== 22'h000010) $display("FAIL wrap_saddr got=%h exp=000010", bus_a.sdram_addr); else n_pass++;
    bus_a.data_read = 16'hA5A5;
    tick();
    n_total++; if (bus_a.dout[47:32] !== 16'hA5A5) $display("FAIL wrap_dout got=%h exp=A5A5", bus_a.dout[47:32]); else n_pass++;
    bus_a.req[2] = 1'b0;
    tick();
  endtask

  task automatic test_refresh();
    logic prev;
    lvbl = 1'b0;
    prev = bus_a.sdram_re;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_total++;
      if (aref_a !== 1'b1) $display("FAIL refresh_high tick=%0d got=%0b exp=1", i, aref_a);
      else n_pass++;
      n_total++;
      if (bus_a.sdram_re !== prev) $display("FAIL refresh_re_static tick=%0d got=%0b exp=%0b", i, bus_a.sdram_re, prev);
      else n_pass++;
    end
    bus_a.addr[87:66] = 22'h000009;
    bus_a.req[3]      = 1'b1;
    tick();
    n_total++; if (aref_a !== 1'b0) $display("FAIL refresh_low_on_grant got=%0b exp=0", aref_a); else n_pass++;
    n_total++; if (bus_a.sdram_re !== ~prev) $display("FAIL refresh_grant_re got=%0b exp=%0b", bus_a.sdram_re, ~prev); else n_pass++;
    n_total++; if (bus_a.sdram_addr !== 22'h000009) $display("FAIL refresh_grant_saddr got=%h exp=000009", bus_a.sdram_addr); else n_pass++;
    lvbl = 1'b1;
    tick();
    bus_a.req[3] = 1'b0;
    tick();
  endtask

  task automatic test_download();
    logic prev;
    bus_b.addr      = {22'h000002, 22'h0, 22'h0, 22'h000001};
    bus_b.req       = 4'b1001;
    bus_b.data_read = 16'h5A5A;
    tick();
    n_total++; if (bus_b.sdram_addr !== 22'h020001) $display("FAIL dl_grant0 got=%h exp=020001", bus_b.sdram_addr); else n_pass++;
    tick();
    n_total++; if (bus_b.sdram_addr !== 22'h000002) $display("FAIL dl_grant3 got=%h exp=000002", bus_b.sdram_addr); else n_pass++;
    prev = bus_b.sdram_re;
    dl_b = 1'b1;
    clk_step();
    dl_b      = 1'b0;
    bus_b.req = '0;
    n_total++; if (ready_b !== 1'b0) $display("FAIL dl_ready_fall got=%0b exp=0", ready_b); else n_pass++;
    n_total++; if (bus_b.sdram_re !== prev) $display("FAIL dl_re_held got=%0b exp=%0b", bus_b.sdram_re, prev); else n_pass++;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_total++;
      if (bus_b.data_ok !== 4'h0) $display("FAIL dl_no_dok tick=%0d got=%b exp=0000", i, bus_b.data_ok);
      else n_pass++;
      n_total++;
      if (ready_b !== (i >= 4)) $display("FAIL dl_ready_rise tick=%0d got=%0b exp=%0b", i, ready_b, (i >= 4));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_word();
    test_byte();
    test_wrap();
    test_refresh();
    test_download();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
